// File: rtl/regfile_pkg.sv
// Shared defaults and the per-byte write-priority rule for the multi-port register file.
package regfile_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_DEPTH     = 32;
  localparam int DEF_NUM_RD    = 2;
  localparam int DEF_DEBUG_REG = 16;

  // Write port 1 has priority over port 0 on every byte both ports enable.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic       en0,
                                            input logic [7:0] d0,
                                            input logic       en1,
                                            input logic [7:0] d1);
    if (en1)      return d1;
    else if (en0) return d0;
    else          return old_b;
  endfunction

endpackage

// File: rtl/regfile_wr_merge.sv
// Merges both write ports into the old contents of one target register.
module regfile_wr_merge
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic [AW-1:0]      tgt_addr,
  input  logic [WIDTH-1:0]   old_val,
  input  logic               wr0_en,
  input  logic [AW-1:0]      wr0_addr,
  input  logic [WIDTH-1:0]   wr0_data,
  input  logic [WIDTH/8-1:0] wr0_be,
  input  logic               wr1_en,
  input  logic [AW-1:0]      wr1_addr,
  input  logic [WIDTH-1:0]   wr1_data,
  input  logic [WIDTH/8-1:0] wr1_be,
  output logic [WIDTH-1:0]   new_val
);

  localparam int BW = WIDTH / 8;

  logic blocked;
  logic hit0;
  logic hit1;

  assign blocked = ZERO_REG && (tgt_addr == '0);
  assign hit0    = wr0_en && (wr0_addr == tgt_addr) && !blocked;
  assign hit1    = wr1_en && (wr1_addr == tgt_addr) && !blocked;

  always_comb begin
    new_val = old_val;
    for (int b = 0; b < BW; b++) begin
      new_val[b*8 +: 8] = merge_byte(old_val[b*8 +: 8],
                                     hit0 && wr0_be[b], wr0_data[b*8 +: 8],
                                     hit1 && wr1_be[b], wr1_data[b*8 +: 8]);
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD combinational read ports, two byte-enabled
// write ports, optional write-to-read bypass and a per-register busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int NUM_RD    = DEF_NUM_RD,
  parameter bit ZERO_REG  = 1'b1,
  parameter bit BYPASS    = 1'b1,
  parameter int DEBUG_REG = DEF_DEBUG_REG,
  localparam int AW       = $clog2(DEPTH),
  localparam int BW       = WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_busy,
  input  logic                    wr0_en,
  input  logic [AW-1:0]           wr0_addr,
  input  logic [WIDTH-1:0]        wr0_data,
  input  logic [BW-1:0]           wr0_be,
  input  logic                    wr1_en,
  input  logic [AW-1:0]           wr1_addr,
  input  logic [WIDTH-1:0]        wr1_data,
  input  logic [BW-1:0]           wr1_be,
  input  logic                    rsv_en,
  input  logic [AW-1:0]           rsv_addr,
  output logic [WIDTH-1:0]        dbg_data
);

  localparam logic [AW-1:0] DBG_IDX = AW'(DEBUG_REG);

  logic [WIDTH-1:0] mem        [DEPTH];
  logic [WIDTH-1:0] commit_val [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;

  for (genvar r = 0; r < DEPTH; r++) begin : g_commit
    regfile_wr_merge #(.WIDTH(WIDTH), .AW(AW), .ZERO_REG(ZERO_REG)) u_merge (
      .tgt_addr (AW'(r)),
      .old_val  (mem[r]),
      .wr0_en   (wr0_en),
      .wr0_addr (wr0_addr),
      .wr0_data (wr0_data),
      .wr0_be   (wr0_be),
      .wr1_en   (wr1_en),
      .wr1_addr (wr1_addr),
      .wr1_data (wr1_data),
      .wr1_be   (wr1_be),
      .new_val  (commit_val[r])
    );
  end

  // Any enabled write clears busy regardless of byte enables; a reserve overrides it.
  always_comb begin
    busy_nxt = busy;
    for (int r = 0; r < DEPTH; r++) begin
      if (ZERO_REG && r == 0) begin
        busy_nxt[r] = 1'b0;
      end else if (rsv_en && rsv_addr == AW'(r)) begin
        busy_nxt[r] = 1'b1;
      end else if ((wr0_en && wr0_addr == AW'(r)) || (wr1_en && wr1_addr == AW'(r))) begin
        busy_nxt[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
      busy <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= commit_val[r];
      busy <= busy_nxt;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] stored;
    logic [WIDTH-1:0] fwd;
    logic             is_zero;

    assign addr    = rd_addr[k*AW +: AW];
    assign stored  = mem[addr];
    assign is_zero = ZERO_REG && (addr == '0);

    regfile_wr_merge #(.WIDTH(WIDTH), .AW(AW), .ZERO_REG(ZERO_REG)) u_byp (
      .tgt_addr (addr),
      .old_val  (stored),
      .wr0_en   (wr0_en),
      .wr0_addr (wr0_addr),
      .wr0_data (wr0_data),
      .wr0_be   (wr0_be),
      .wr1_en   (wr1_en),
      .wr1_addr (wr1_addr),
      .wr1_data (wr1_data),
      .wr1_be   (wr1_be),
      .new_val  (fwd)
    );

    assign rd_data[k*WIDTH +: WIDTH] = is_zero ? '0 : (BYPASS ? fwd : stored);
    assign rd_busy[k]                = is_zero ? 1'b0 : (BYPASS ? busy_nxt[addr] : busy[addr]);
  end

  assign dbg_data = mem[DBG_IDX];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: a default (bypassing, zero-reg) instance and a plain instance share stimulus.
module tb_regfile_mp;

  localparam int AW = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic        wr0_en, wr1_en, rsv_en;
  logic [4:0]  wr0_addr, wr1_addr, rsv_addr;
  logic [31:0] wr0_data, wr1_data;
  logic [3:0]  wr0_be, wr1_be;

  logic [63:0] a_rd_data, b_rd_data;
  logic [1:0]  a_rd_busy, b_rd_busy;
  logic [31:0] a_dbg, b_dbg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_mp dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_be(wr0_be),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_be(wr1_be),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .dbg_data(a_dbg)
  );

  regfile_mp #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_be(wr0_be),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_be(wr1_be),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .dbg_data(b_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr1_en = 1'b0; rsv_en = 1'b0;
    wr0_be = 4'h0; wr1_be = 4'h0;
  endtask

  // Advance past the next rising edge and settle mid-low-phase for checks.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = '0;
    wr0_addr = '0; wr1_addr = '0; rsv_addr = '0;
    wr0_data = '0; wr1_data = '0;
    idle();
    #3;
    check("rst_a_rd0", a_rd_data[31:0], 32'h0);
    check("rst_a_busy", 32'(a_rd_busy), 32'h0);
    check("rst_b_dbg", b_dbg, 32'h0);

    next_cycle();
    rst_n = 1'b1;

    // Byte write: full then partial
    rd_addr = {5'd9, 5'd3};
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h11223344; wr0_be = 4'hF;
    #1;
    check("byp_a_full", a_rd_data[31:0], 32'h11223344);
    check("nobyp_b_full", b_rd_data[31:0], 32'h0);
    next_cycle();
    wr0_data = 32'hAAAAAAAA; wr0_be = 4'b0010;
    #1;
    check("b_full_commit", b_rd_data[31:0], 32'h11223344);
    check("byp_a_part", a_rd_data[31:0], 32'h1122AA44);
    next_cycle();
    idle();
    #1;
    check("a_part", a_rd_data[31:0], 32'h1122AA44);
    check("b_part", b_rd_data[31:0], 32'h1122AA44);

    // Port conflict on reg 7
    rd_addr = {5'd9, 5'd7};
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11111111; wr0_be = 4'hF;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22222222; wr1_be = 4'b0011;
    #1;
    check("byp_a_conf", a_rd_data[31:0], 32'h11112222);
    next_cycle();
    idle();
    #1;
    check("a_conf", a_rd_data[31:0], 32'h11112222);
    check("b_conf", b_rd_data[31:0], 32'h11112222);

    // Bypass vs debug tap on reg 16
    rd_addr = {5'd9, 5'd16};
    wr1_en = 1'b1; wr1_addr = 5'd16; wr1_data = 32'd2467; wr1_be = 4'hF;
    #1;
    check("byp_a_16", a_rd_data[31:0], 32'd2467);
    check("dbg_a_pre", a_dbg, 32'h0);
    check("nobyp_b_16", b_rd_data[31:0], 32'h0);
    next_cycle();
    idle();
    #1;
    check("dbg_a_post", a_dbg, 32'd2467);
    check("dbg_b_post", b_dbg, 32'd2467);
    check("b_16", b_rd_data[31:0], 32'd2467);

    // Scoreboard on reg 9 (read port 1)
    rsv_en = 1'b1; rsv_addr = 5'd9;
    #1;
    check("sb_a_byp", 32'(a_rd_busy[1]), 32'h1);
    check("sb_b_pre", 32'(b_rd_busy[1]), 32'h0);
    next_cycle();
    idle();
    #1;
    check("sb_b_set", 32'(b_rd_busy[1]), 32'h1);
    rsv_en = 1'b1; rsv_addr = 5'd9;
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h5; wr0_be = 4'h0;
    next_cycle();
    idle();
    #1;
    check("sb_a_rsvwins", 32'(a_rd_busy[1]), 32'h1);
    check("sb_b_rsvwins", 32'(b_rd_busy[1]), 32'h1);
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h5; wr0_be = 4'h0;
    #1;
    check("sb_a_clr_byp", 32'(a_rd_busy[1]), 32'h0);
    check("sb_b_clr_pre", 32'(b_rd_busy[1]), 32'h1);
    next_cycle();
    idle();
    #1;
    check("sb_b_clr", 32'(b_rd_busy[1]), 32'h0);

    // Zero register
    rd_addr = {5'd0, 5'd0};
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFFFFFF; wr0_be = 4'hF;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    #1;
    check("z_a_byp", a_rd_data[31:0], 32'h0);
    check("z_a_busy_byp", 32'(a_rd_busy[0]), 32'h0);
    next_cycle();
    idle();
    #1;
    check("z_a_rd", a_rd_data[63:32], 32'h0);
    check("z_a_busy", 32'(a_rd_busy[1]), 32'h0);
    check("z_b_rd", b_rd_data[31:0], 32'hFFFFFFFF);
    check("z_b_busy", 32'(b_rd_busy[0]), 32'h1);

    // Asynchronous reset with reg 5 populated and reserved
    rd_addr = {5'd5, 5'd5};
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF; wr0_be = 4'hF;
    rsv_en = 1'b1; rsv_addr = 5'd5;
    next_cycle();
    idle();
    #1;
    check("r5_b_val", b_rd_data[31:0], 32'hDEADBEEF);
    check("r5_a_busy", 32'(a_rd_busy[0]), 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_a_rd", a_rd_data[31:0], 32'h0);
    check("arst_b_rd", b_rd_data[63:32], 32'h0);
    check("arst_a_busy", 32'(a_rd_busy), 32'h0);
    check("arst_a_dbg", a_dbg, 32'h0);
    check("arst_b_dbg", b_dbg, 32'h0);

    // Write presented while reset is held is lost
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'h12345678; wr0_be = 4'hF;
    next_cycle();
    idle();
    rst_n = 1'b1;
    #1;
    check("rst_wr_lost_a", a_rd_data[31:0], 32'h0);
    check("rst_wr_lost_b", b_rd_data[31:0], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
